// File: rtl/tft_tx_buffer.sv
// Byte FIFO feeding the SPI byte transmitter through a launch/ack/drain handshake.
// Optional drop statistics are compiled in with TFT_TX_BUFFER_DROP_CNT_EN.
module tft_tx_buffer #(
    parameter int DEPTH_LOG2  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_dc,
    input  logic                  in_transmit,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  idle,
    output logic [7:0]            spi_data,
    output logic                  spi_dc,
    output logic                  spi_transmit,
    input  logic                  spi_busy,
    output logic                  ack_timeout
`ifdef TFT_TX_BUFFER_DROP_CNT_EN
    ,
    output logic [15:0]           drop_count,
    output logic                  overflow
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   ONE_COUNT    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] ONE_PTR      = DEPTH_LOG2'(1);
    localparam logic [15:0]           TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACK   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [8:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [15:0]           timer_reg;
    logic [7:0]            spi_data_reg;
    logic                  spi_dc_reg;
    logic                  ack_timeout_reg;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  ack_expired;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    // A push while full is dropped even when a pop frees a slot this cycle.
    assign push  = in_transmit && !full;
    assign pop   = (state_reg == ST_IDLE) && !empty && !spi_busy;
    assign ack_expired = (state_reg == ST_ACK) && !spi_busy && (timer_reg == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_dc, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ONE_PTR;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ONE_PTR;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + ONE_COUNT;
                2'b01:   count_reg <= count_reg - ONE_COUNT;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pop) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (spi_busy) begin
                    state_next = ST_DRAIN;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!spi_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The output byte register doubles as the FIFO's registered read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            timer_reg       <= '0;
            spi_data_reg    <= '0;
            spi_dc_reg      <= 1'b0;
            ack_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ack_timeout_reg <= ack_expired;
            if (pop) begin
                spi_data_reg <= mem[rd_ptr_reg][7:0];
                spi_dc_reg   <= mem[rd_ptr_reg][8];
                timer_reg    <= '0;
            end else if ((state_reg == ST_ACK) && (state_next == ST_ACK)) begin
                timer_reg <= timer_reg + 16'd1;
            end
        end
    end

    // Launch request is simply "in ACK", so an async reset drops it at once.
    assign spi_transmit = (state_reg == ST_ACK);
    assign spi_data     = spi_data_reg;
    assign spi_dc       = spi_dc_reg;
    assign ack_timeout  = ack_timeout_reg;
    assign busy         = full;
    assign level        = count_reg;
    assign idle         = empty && (state_reg == ST_IDLE) && !spi_busy;

`ifdef TFT_TX_BUFFER_DROP_CNT_EN
    logic [15:0] drop_count_reg;
    logic        overflow_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else if (in_transmit && full) begin
            if (drop_count_reg != 16'hFFFF) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end
            overflow_reg <= 1'b1;
        end
    end

    assign drop_count = drop_count_reg;
    assign overflow   = overflow_reg;
`endif

endmodule

// File: tb/tb_tft_tx_buffer.sv
// Bench for tft_tx_buffer: directed tables and sequences plus randomized traffic
// scored against a queue-based protocol model. Honours TFT_TX_BUFFER_DROP_CNT_EN.
`timescale 1ns/1ps
module tb_tft_tx_buffer;

    localparam int DEPTH_LOG2  = 4;
    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          in_data;
    logic                in_dc;
    logic                in_transmit;
    logic                busy;
    logic [DEPTH_LOG2:0] level;
    logic                idle;
    logic [7:0]          spi_data;
    logic                spi_dc;
    logic                spi_transmit;
    logic                spi_busy;
    logic                ack_timeout;
`ifdef TFT_TX_BUFFER_DROP_CNT_EN
    logic [15:0]         drop_count;
    logic                overflow;
`endif

    always #5 clk = ~clk;

    tft_tx_buffer #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_dc        (in_dc),
        .in_transmit  (in_transmit),
        .busy         (busy),
        .level        (level),
        .idle         (idle),
        .spi_data     (spi_data),
        .spi_dc       (spi_dc),
        .spi_transmit (spi_transmit),
        .spi_busy     (spi_busy),
        .ack_timeout  (ack_timeout)
`ifdef TFT_TX_BUFFER_DROP_CNT_EN
        ,
        .drop_count   (drop_count),
        .overflow     (overflow)
`endif
    );

    typedef struct {
        logic       dc;
        logic [7:0] data;
        logic       exp_dc;
        logic [7:0] exp_data;
    } vec_t;

    vec_t fill_vec [16];
    vec_t dc_vec   [4];

    int tests = 0;
    int fails = 0;

    // Protocol model: queued words, launch-in-progress, waiting for transmitter release.
    logic [8:0] m_q [$];
    logic       m_tx;
    logic       m_drain;
    int         m_cnt;
    logic [8:0] m_out;
    int         m_drops;
    logic       m_ovf;

    logic [8:0] launched [$];
    int         ack_pulses;

    // Transmitter model state
    bit auto_xmit;
    int xm_wait;
    int xm_left;
    bit xm_ignore;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_tx    = 1'b0;
        m_drain = 1'b0;
        m_cnt   = 0;
        m_out   = '0;
        m_drops = 0;
        m_ovf   = 1'b0;
        xm_wait = 0;
        xm_left = 0;
        xm_ignore = 1'b0;
    endtask

    task automatic xmit_drive();
        if (!auto_xmit) return;
        if (xm_left > 0) begin
            spi_busy = 1'b1;
            xm_left--;
        end else if (spi_transmit && !xm_ignore && !spi_busy) begin
            if (xm_wait == 0) begin
                spi_busy = 1'b1;
                xm_left  = $urandom_range(0, 5);
            end else begin
                xm_wait--;
                spi_busy = 1'b0;
            end
        end else begin
            spi_busy = 1'b0;
        end
    endtask

    // One clock: inputs already set by the caller, sample and score #1 after the edge.
    task automatic step();
        logic       push_ok;
        logic       busy_b;
        logic       launch;
        logic       exp_ack;
        logic [8:0] word_b;
        logic [8:0] head;
        xmit_drive();
        busy_b  = spi_busy;
        word_b  = {in_dc, in_data};
        push_ok = in_transmit && (m_q.size() < DEPTH);
        if (in_transmit && !push_ok) begin
            if (m_drops < 65535) m_drops++;
            m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        launch  = 1'b0;
        exp_ack = 1'b0;
        head    = '0;
        if (m_tx) begin
            if (busy_b) begin
                m_tx    = 1'b0;
                m_drain = 1'b1;
            end else if (m_cnt == ACK_TIMEOUT) begin
                m_tx    = 1'b0;
                exp_ack = 1'b1;
            end else begin
                m_cnt++;
            end
        end else if (m_drain) begin
            if (!busy_b) m_drain = 1'b0;
        end else if (m_q.size() > 0 && !busy_b) begin
            head   = m_q.pop_front();
            launch = 1'b1;
            m_tx   = 1'b1;
            m_cnt  = 1;
            m_out  = head;
        end
        if (push_ok) m_q.push_back(word_b);

        chk("spi_transmit", {31'd0, spi_transmit}, {31'd0, m_tx});
        chk("ack_timeout", {31'd0, ack_timeout}, {31'd0, exp_ack});
        chk("spi_word", {23'd0, spi_dc, spi_data}, {23'd0, m_out});
        chk("level", {27'd0, level}, m_q.size());
        chk("busy", {31'd0, busy}, {31'd0, (m_q.size() == DEPTH)});
        chk("idle", {31'd0, idle},
            {31'd0, (m_q.size() == 0 && !m_tx && !m_drain && !spi_busy)});
`ifdef TFT_TX_BUFFER_DROP_CNT_EN
        chk("drop_count", {16'd0, drop_count}, m_drops);
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`endif
        if (ack_timeout) ack_pulses++;
        if (launch) begin
            launched.push_back(head);
            xm_wait   = $urandom_range(0, 2);
            xm_ignore = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        in_transmit = 1'b0;
        while (!(idle && m_q.size() == 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", {31'd0, idle}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int n;
        for (int i = 0; i < 16; i++) begin
            fill_vec[i].dc       = (i % 3 == 0);
            fill_vec[i].data     = 8'(i);
            fill_vec[i].exp_dc   = (i % 3 == 0);
            fill_vec[i].exp_data = 8'(i);
        end
        dc_vec[0] = '{1'b1, 8'h2C, 1'b1, 8'h2C};
        dc_vec[1] = '{1'b0, 8'h11, 1'b0, 8'h11};
        dc_vec[2] = '{1'b1, 8'h2B, 1'b1, 8'h2B};
        dc_vec[3] = '{1'b0, 8'h22, 1'b0, 8'h22};

        // Reset state
        rst = 1'b0; in_data = '0; in_dc = 1'b0; in_transmit = 1'b0; spi_busy = 1'b0;
        auto_xmit = 1'b0; ack_pulses = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_spi_transmit", {31'd0, spi_transmit}, 32'd0);
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_ack_timeout", {31'd0, ack_timeout}, 32'd0);
        chk("rst_spi_word", {23'd0, spi_dc, spi_data}, 32'd0);
        spi_busy = 1'b1;
        #1;
        chk("rst_idle_follows_busy", {31'd0, idle}, 32'd0);
        spi_busy = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Single byte: launch latency and handshake
        in_dc = 1'b0; in_data = 8'h2A; in_transmit = 1'b1;
        step();
        in_transmit = 1'b0;
        chk("t1_no_tx_yet", {31'd0, spi_transmit}, 32'd0);
        step();
        chk("t1_tx_at_t2", {31'd0, spi_transmit}, 32'd1);
        chk("t1_data", {24'd0, spi_data}, 32'h2A);
        chk("t1_dc", {31'd0, spi_dc}, 32'd0);
        spi_busy = 1'b1;
        step();
        chk("t1_tx_fall", {31'd0, spi_transmit}, 32'd0);
        repeat (7) begin
            step();
            chk("t1_not_idle", {31'd0, idle}, 32'd0);
        end
        spi_busy = 1'b0;
        step();
        chk("t1_idle", {31'd0, idle}, 32'd1);

        // Fill to full with transmitter busy, overflow, then push+pop while full
        launched.delete();
        spi_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_dc = fill_vec[i].dc; in_data = fill_vec[i].data; in_transmit = 1'b1;
            step();
        end
        in_transmit = 1'b0;
        chk("t2_level_full", {27'd0, level}, 32'd16);
        chk("t2_busy_full", {31'd0, busy}, 32'd1);
        in_dc = 1'b1; in_data = 8'hFF; in_transmit = 1'b1;
        step();
        in_transmit = 1'b0;
        chk("t2_drop_level", {27'd0, level}, 32'd16);
`ifdef TFT_TX_BUFFER_DROP_CNT_EN
        chk("t2_drop_count", {16'd0, drop_count}, 32'd1);
`endif
        in_dc = 1'b0; in_data = 8'hEE; in_transmit = 1'b1; spi_busy = 1'b0;
        step();
        in_transmit = 1'b0;
        chk("t2_pushpop_level", {27'd0, level}, 32'd15);
        chk("t2_pushpop_tx", {31'd0, spi_transmit}, 32'd1);
`ifdef TFT_TX_BUFFER_DROP_CNT_EN
        chk("t2_drop_count2", {16'd0, drop_count}, 32'd2);
        chk("t2_overflow", {31'd0, overflow}, 32'd1);
`endif
        auto_xmit = 1'b1;
        wait_idle(600);
        chk("t2_count", launched.size(), 32'd16);
        for (int i = 0; i < 16 && i < launched.size(); i++) begin
            chk("t2_order", {23'd0, launched[i]}, {23'd0, fill_vec[i].exp_dc, fill_vec[i].exp_data});
        end

        // dc/data pairing table
        launched.delete();
        for (int i = 0; i < 4; i++) begin
            in_dc = dc_vec[i].dc; in_data = dc_vec[i].data; in_transmit = 1'b1;
            step();
        end
        wait_idle(300);
        chk("t3_count", launched.size(), 32'd4);
        for (int i = 0; i < 4 && i < launched.size(); i++) begin
            chk("t3_pair", {23'd0, launched[i]}, {23'd0, dc_vec[i].exp_dc, dc_vec[i].exp_data});
        end

        // ACK timeout with transmitter stuck idle
        auto_xmit = 1'b0; spi_busy = 1'b0; ack_pulses = 0;
        in_dc = 1'b1; in_data = 8'h55; in_transmit = 1'b1;
        step();
        in_dc = 1'b0; in_data = 8'h66;
        step();
        in_transmit = 1'b0;
        chk("t4_launch", {31'd0, spi_transmit}, 32'd1);
        chk("t4_word", {23'd0, spi_dc, spi_data}, 32'h155);
        hi = 1; n = 0;
        while (spi_transmit && n < 40) begin
            step();
            if (spi_transmit) hi++;
            n++;
        end
        chk("t4_high_cycles", hi, ACK_TIMEOUT);
        chk("t4_ack_pulse", {31'd0, ack_timeout}, 32'd1);
        chk("t4_pulse_count", ack_pulses, 32'd1);
        step();
        chk("t4_next_launch", {31'd0, spi_transmit}, 32'd1);
        chk("t4_next_word", {23'd0, spi_dc, spi_data}, 32'h066);
        chk("t4_pulse_single", {31'd0, ack_timeout}, 32'd0);
        wait_idle(100);

        // Reset while in ACK with 5 bytes queued
        for (int i = 0; i < 6; i++) begin
            in_dc = 1'(i); in_data = 8'h80 + 8'(i); in_transmit = 1'b1;
            step();
        end
        in_transmit = 1'b0;
        chk("t5_level_before", {27'd0, level}, 32'd5);
        chk("t5_in_ack", {31'd0, spi_transmit}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_tx_dropped", {31'd0, spi_transmit}, 32'd0);
        chk("t5_level_cleared", {27'd0, level}, 32'd0);
        chk("t5_busy_cleared", {31'd0, busy}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        launched.delete();
        repeat (20) step();
        chk("t5_no_launch", launched.size(), 32'd0);

        // Randomized traffic against the model
        auto_xmit = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            in_transmit = ($urandom_range(0, 99) < 45);
            in_data     = 8'($urandom);
            in_dc       = 1'($urandom);
            step();
        end
        wait_idle(2000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
